// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and helpers for the memory-access / MEM-WB stage.
package mem_wb_stage_pkg;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Size code 2'b11 falls into the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = |lo;
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/data replication and load extraction/extension.
module mem_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ldata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_c     = 4'b1111;
    wdata_c  = wdata_i;
    ldata_c  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr_lo_i;
        wdata_c = {4{wdata_i[7:0]}};
        ldata_c = {{24{sext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_c    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_i[15:0]}};
        ldata_c = {{16{sext_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register, req/ack data bus,
// misalignment detection and bus timeout.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_M,
  input  logic        flush_M,
  input  logic [31:0] Instr_M,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] WData_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] PC8_M,
  input  logic [4:0]  A3_M,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [1:0]  mem_size_M,
  input  logic        mem_sext_M,
  output logic        stall_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] Instr_W,
  output logic [31:0] ALUout_W,
  output logic [31:0] PC4_W,
  output logic [31:0] PC8_W,
  output logic [4:0]  A3_W,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic [31:0] exc_epc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      instr_q, alu_q, pc4_q, pc8_q, epc_q;
  logic [4:0]       a3_q;
  logic             adel_q, ades_q, bus_q;

  logic        memop, misal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ldata_c;

  mem_align u_align (
    .size_i    (mem_size_M),
    .addr_lo_i (ALUout_M[1:0]),
    .sext_i    (mem_sext_M),
    .wdata_i   (WData_M),
    .rdata_i   (dbus_rdata),
    .be_c      (be_c),
    .wdata_c   (wdata_c),
    .ldata_c   (ldata_c)
  );

  always_comb begin
    memop   = valid_M & ~flush_M & (mem_rd_M | mem_wr_M);
    misal   = misaligned(mem_size_M, ALUout_M[1:0]);
    stall_M = 1'b0;
    case (state_q)
      IDLE:    stall_M = memop & ~misal;
      BUSY:    stall_M = ~dbus_ack & (cnt_q != CNT_LAST);
      default: stall_M = 1'b0;
    endcase
  end

  // FSM, timeout counter and W register; every branch starts from a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      instr_q <= NOP_INSTR;
      alu_q   <= '0;
      pc4_q   <= '0;
      pc8_q   <= '0;
      a3_q    <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      bus_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      instr_q <= NOP_INSTR;
      alu_q   <= '0;
      a3_q    <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      bus_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memop && misal) begin
            adel_q <= ~mem_wr_M;
            ades_q <= mem_wr_M;
            epc_q  <= PC4_M - 32'd4;
          end else if (memop) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= mem_wr_M;
            addr_q  <= {ALUout_M[31:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end else if (valid_M && !flush_M) begin
            instr_q <= Instr_M;
            alu_q   <= ALUout_M;
            pc4_q   <= PC4_M;
            pc8_q   <= PC8_M;
            a3_q    <= A3_M;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            instr_q <= Instr_M;
            alu_q   <= we_q ? ALUout_M : ldata_c;
            pc4_q   <= PC4_M;
            pc8_q   <= PC8_M;
            a3_q    <= A3_M;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            bus_q   <= 1'b1;
            epc_q   <= PC4_M - 32'd4;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign Instr_W    = instr_q;
  assign ALUout_W   = alu_q;
  assign PC4_W      = pc4_q;
  assign PC8_W      = pc8_q;
  assign A3_W       = a3_q;
  assign exc_adel   = adel_q;
  assign exc_ades   = ades_q;
  assign exc_bus    = bus_q;
  assign exc_epc    = epc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver acts as M stage and bus slave, monitor checks W/exception outputs.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_M, flush_M, mem_rd_M, mem_wr_M, mem_sext_M;
  logic [31:0] Instr_M, ALUout_M, WData_M, PC4_M, PC8_M;
  logic [4:0]  A3_M;
  logic [1:0]  mem_size_M;
  logic        stall_M, dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic [31:0] Instr_W, ALUout_W, PC4_W, PC8_W, exc_epc;
  logic [4:0]  A3_W;
  logic        exc_adel, exc_ades, exc_bus;

  typedef struct {
    logic [31:0] instr, alu, pc4, pc8, epc;
    logic [4:0]  a3;
    logic        is_exc, adel, ades, bus;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_pc4 = 32'h0;
  logic [31:0] last_pc8 = 32'h0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .valid_M(valid_M), .flush_M(flush_M),
    .Instr_M(Instr_M), .ALUout_M(ALUout_M), .WData_M(WData_M), .PC4_M(PC4_M),
    .PC8_M(PC8_M), .A3_M(A3_M), .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
    .mem_size_M(mem_size_M), .mem_sext_M(mem_sext_M), .stall_M(stall_M),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .Instr_W(Instr_W), .ALUout_W(ALUout_W), .PC4_W(PC4_W), .PC8_W(PC8_W), .A3_W(A3_W),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus), .exc_epc(exc_epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_wb(input logic [31:0] instr, alu, pc4, input logic [4:0] a3);
    rec_t r;
    r.is_exc = 1'b0; r.instr = instr; r.alu = alu; r.pc4 = pc4; r.pc8 = pc4 + 32'd4;
    r.a3 = a3; r.adel = 1'b0; r.ades = 1'b0; r.bus = 1'b0; r.epc = 32'h0;
    last_pc4 = pc4;
    last_pc8 = pc4 + 32'd4;
    exp_q.push_back(r);
  endtask

  task automatic push_exc(input logic adel, ades, bus, input logic [31:0] pc4);
    rec_t r;
    r.is_exc = 1'b1; r.instr = 32'h0; r.alu = 32'h0; r.pc4 = last_pc4; r.pc8 = last_pc8;
    r.a3 = 5'd0; r.adel = adel; r.ades = ades; r.bus = bus; r.epc = pc4 - 32'd4;
    exp_q.push_back(r);
  endtask

  // Monitor: anything leaving the stage (a real instruction or an exception) must match the queue head.
  always @(negedge clk) begin
    rec_t r;
    if (reset_n === 1'b1 && (Instr_W != 32'h0 || exc_adel || exc_ades || exc_bus)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output instr=%h exc=%b%b%b", Instr_W, exc_adel, exc_ades, exc_bus);
      end else begin
        r = exp_q.pop_front();
        check("W_instr", Instr_W, r.instr);
        check("W_aluout", ALUout_W, r.alu);
        check("W_pc4", PC4_W, r.pc4);
        check("W_pc8", PC8_W, r.pc8);
        check("W_a3", 32'(A3_W), 32'(r.a3));
        check("exc_flags", {29'h0, exc_adel, exc_ades, exc_bus}, {29'h0, r.adel, r.ades, r.bus});
        if (r.is_exc) check("exc_epc", exc_epc, r.epc);
      end
    end
  end

  // One M-stage instruction; lat = no-ack BUSY cycles before the ack (>= TO means no ack).
  task automatic run_op(input logic valid, flush, rd, wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] instr, addr, wd, pc4, input logic [4:0] a3,
                        input int lat, input logic [31:0] rdata);
    int          nb;
    logic        memop, mis;
    logic [1:0]  lo;
    logic [3:0]  be_e;
    logic [31:0] wd_e, ld_e, sh, tmp;
    @(negedge clk);
    valid_M = valid; flush_M = flush; mem_rd_M = rd; mem_wr_M = wr;
    mem_size_M = size; mem_sext_M = sext; Instr_M = instr; ALUout_M = addr;
    WData_M = wd; PC4_M = pc4; PC8_M = pc4 + 32'd4; A3_M = a3;
    dbus_ack = 1'b0; dbus_rdata = rdata;
    nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    lo    = addr[1:0];
    memop = valid && !flush && (rd || wr);
    mis   = (int'(lo) % nb) != 0;
    for (int i = 0; i < 4; i++) begin
      be_e[i] = (i >= int'(lo)) && (i < int'(lo) + nb);
      tmp = wd >> (8 * (i % nb));
      wd_e[8*i +: 8] = tmp[7:0];
    end
    sh = rdata >> (8 * int'(lo));
    if (nb == 1)      ld_e = sext ? 32'($signed(sh[7:0]))  : {24'h0, sh[7:0]};
    else if (nb == 2) ld_e = sext ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
    else              ld_e = rdata;
    #1;
    check("idle_req", 32'(dbus_req), 32'h0);
    check("idle_stall", 32'(stall_M), 32'(memop && !mis));
    if (!memop) begin
      if (valid && !flush) push_wb(instr, addr, pc4, a3);
    end else if (mis) begin
      push_exc(!wr, wr, 1'b0, pc4);
    end else begin
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        dbus_ack = (k == lat);
        flush_M  = 1'($urandom_range(0, 1));
        #1;
        check("busy_req", 32'(dbus_req), 32'h1);
        check("busy_we", 32'(dbus_we), 32'(wr));
        check("busy_addr", dbus_addr, {addr[31:2], 2'b00});
        if (wr) begin
          check("busy_be", 32'(dbus_be), 32'(be_e));
          check("busy_wdata", dbus_wdata, wd_e);
        end
        check("busy_stall", 32'(stall_M), 32'((k != lat) && (k != TO - 1)));
        if (k == lat) begin
          push_wb(instr, (rd && !wr) ? ld_e : addr, pc4, a3);
          break;
        end
        if (k == TO - 1) push_exc(1'b0, 1'b0, 1'b1, pc4);
      end
    end
  endtask

  task automatic reset_mid_busy();
    run_op(1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0022_1820, 32'h0000_0055, 32'h0,
           32'h0000_5004, 5'd3, 0, 32'h0);
    @(negedge clk);
    valid_M = 1'b1; flush_M = 1'b0; mem_rd_M = 1'b1; mem_wr_M = 1'b0; mem_size_M = SZ_WORD;
    Instr_M = 32'h8C43_0000; ALUout_M = 32'h0000_3000; PC4_M = 32'h0000_5008;
    PC8_M = 32'h0000_500C; dbus_ack = 1'b0;
    @(negedge clk);
    #1;
    check("rst_pre_req", 32'(dbus_req), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_req", 32'(dbus_req), 32'h0);
    check("rst_instr_w", Instr_W, 32'h0);
    check("rst_alu_w", ALUout_W, 32'h0);
    check("rst_pc4_w", PC4_W, 32'h0);
    check("rst_pc8_w", PC8_W, 32'h0);
    check("rst_a3_w", 32'(A3_W), 32'h0);
    last_pc4 = 32'h0;
    last_pc8 = 32'h0;
    @(negedge clk);
    valid_M = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    logic        rd, wr;
    int          kind;
    reset_n = 1'b0;
    valid_M = 1'b0; flush_M = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0; mem_sext_M = 1'b0;
    mem_size_M = 2'b00; Instr_M = 32'h0; ALUout_M = 32'h0; WData_M = 32'h0;
    PC4_M = 32'h0; PC8_M = 32'h0; A3_M = 5'd0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req", 32'(dbus_req), 32'h0);
    check("reset_be", 32'(dbus_be), 32'h0);
    check("reset_addr", dbus_addr, 32'h0);
    check("reset_instr_w", Instr_W, 32'h0);
    check("reset_pc4_w", PC4_W, 32'h0);
    check("reset_exc", {29'h0, exc_adel, exc_ades, exc_bus}, 32'h0);
    reset_n = 1'b1;

    // Directed: ALU op, lb with sign extension, sh, misaligned lw, lw timeout.
    run_op(1, 0, 0, 0, SZ_WORD, 0, 32'h0109_5020, 32'h0000_1234, 32'h0, 32'h0000_3004, 5'd10, 0, 32'h0);
    run_op(1, 0, 1, 0, SZ_BYTE, 1, 32'h8044_0003, 32'h0000_1003, 32'h0, 32'h0000_3008, 5'd4, 3, 32'h80FF_FF00);
    run_op(1, 0, 0, 1, SZ_HALF, 0, 32'hA445_0002, 32'h0000_2002, 32'h0000_BEEF, 32'h0000_300C, 5'd5, 1, 32'h0);
    run_op(1, 0, 1, 0, SZ_WORD, 0, 32'h8C46_0006, 32'h0000_0006, 32'h0, 32'h0000_3010, 5'd6, 0, 32'h0);
    run_op(1, 0, 1, 0, SZ_WORD, 0, 32'h8C47_4000, 32'h0000_4000, 32'h0, 32'h0000_3014, 5'd7, 100, 32'h0);
    reset_mid_busy();
    run_op(1, 0, 1, 0, SZ_HALF, 0, 32'h9448_0102, 32'h0000_0102, 32'h0, 32'h0000_3018, 5'd8, 0, 32'hCAFE_8001);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind >= 2 && kind <= 4) || (kind == 1 && $urandom_range(0, 1) == 1);
      wr   = (kind >= 5 && kind <= 7);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == SZ_HALF) addr[0] = 1'b0;
        else if (size != SZ_BYTE) addr[1:0] = 2'b00;
      end
      run_op(kind != 0, kind == 1, rd, wr, size, 1'($urandom_range(0, 1)),
             $urandom | 32'h1, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 5), $urandom);
    end

    @(negedge clk);
    valid_M = 1'b0;
    dbus_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly upstream of the writeback stage.
- Takes the M-stage bundle and performs any load/store over a req/ack data bus. Stalls the M stage while the bus is busy.
- Registers the W-stage bundle. For loads, the aligned and extended load data is merged into ALUout_W, so writeback uses ALUout_W directly as write data.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of BUSY cycles without dbus_ack before a bus error is raised. Range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_M  in  1  the M-stage bundle holds a real instruction.
- flush_M  in  1  discard the M-stage instruction.
- Instr_M  in  32  instruction word.
- ALUout_M  in  32  ALU result; this is the memory address for loads and stores.
- WData_M  in  32  store data (rt value).
- PC4_M  in  32  PC+4.
- PC8_M  in  32  PC+8.
- A3_M  in  5  destination register.
- mem_rd_M  in  1  instruction is a load.
- mem_wr_M  in  1  instruction is a store.
- mem_size_M  in  2  access size: 00 byte, 01 half, 10 word.
- mem_sext_M  in  1  sign-extend the load result.
- stall_M  out  1  M stage must hold its inputs stable.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write strobe.
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  write data.
- dbus_ack  in  1  transfer complete; rdata is valid in the same cycle.
- dbus_rdata  in  32  read data.
- Instr_W  out  32  W-stage instruction.
- ALUout_W  out  32  W-stage result (ALU result or load data).
- PC4_W  out  32  W-stage PC+4.
- PC8_W  out  32  W-stage PC+8.
- A3_W  out  5  W-stage destination register.
- exc_adel  out  1  one-cycle pulse: misaligned load.
- exc_ades  out  1  one-cycle pulse: misaligned store.
- exc_bus  out  1  one-cycle pulse: bus timeout.
- exc_epc  out  32  PC of the faulting instruction (PC4-4); valid while any exc_* pulse is high.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Instr_W, ALUout_W, PC4_W, PC8_W, A3_W all 0.
  - dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata all 0.
  - exc_* all 0; timeout counter 0; state IDLE.
- Bubble: Instr_W=0 (nop), A3_W=0, ALUout_W=0, PC4_W and PC8_W hold their previous values. Writeback therefore performs no register write.
- Define memop = valid_M & ~flush_M & (mem_rd_M | mem_wr_M).
- Misalignment rules:
  - Half access is misaligned when addr[0]=1.
  - Word access is misaligned when addr[1:0]!=0.
  - mem_size_M=11 is treated as word.
- State IDLE:
  - Not memop: next edge registers the M bundle into W (bubble if ~valid_M or flush_M). stall_M=0.
  - memop and misaligned: stall_M=0. Next edge: exc_adel/exc_ades pulses for one cycle, exc_epc is captured, W gets a bubble. No bus traffic.
  - memop and aligned: stall_M=1 combinationally. Next edge: enter BUSY; register dbus_addr/be/wdata/we; set dbus_req=1; W gets a bubble.
- State BUSY:
  - dbus_req is held at 1 with stable addr/be/wdata/we.
  - stall_M = ~dbus_ack, so it is deasserted in the ack cycle and M advances on that same edge.
  - dbus_ack=1 at the edge: W captures the bundle. For loads, ALUout_W = aligned load data; for stores, ALUout_W = ALUout_M. dbus_req drops; return to IDLE; counter cleared.
  - No ack: counter increments. When counter==TIMEOUT_CYCLES-1 and still no ack: exc_bus pulse, exc_epc captured, W bubble, req dropped, return to IDLE, stall_M=0 in that cycle.
  - flush_M is ignored in BUSY; the access is already committed.
- Store byte enables and data:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{WData[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{WData[15:0]}}.
  - word: be = 1111; wdata = WData.
- Load alignment:
  - byte: the byte selected by addr[1:0].
  - half: the half selected by addr[1].
  - Extension is sign or zero according to mem_sext_M. Word loads pass through unchanged.
- Reset asserted mid-BUSY aborts immediately: req drops asynchronously, state returns to IDLE.
- The outstanding dbus_req never deasserts before ack or timeout.

Decomposition:
- Shared package:
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding: IDLE, BUSY.
  - NOP_INSTR=32'h0.
- Sub-module mem_align: purely combinational. Generates be/wdata from (size, addr[1:0], WData) and the extended load data from (size, sext, addr[1:0], rdata).
- The stage module holds the FSM, timeout counter and W registers.

Test Plan:
- ALU op (add), valid_M=1, no memop, ALUout_M=32'h1234 → next edge: Instr_W=Instr_M, ALUout_W=32'h1234, stall_M=0, no dbus_req.
- lb, addr 32'h0000_1003, sext=1, ack after 3 BUSY cycles, rdata=32'h80FF_FF00 → stall_M high 4 cycles, dbus_addr=32'h0000_1000, ALUout_W=32'hFFFF_FF80.
- sh, addr 32'h0000_2002, WData=32'h0000_BEEF → dbus_be=4'b1100, dbus_wdata=32'hBEEF_BEEF, dbus_we=1; W receives the instruction on the ack edge.
- lw, addr 32'h0000_0006 → exc_adel one-cycle pulse, exc_epc=PC4_M-4, W bubble (Instr_W=0), dbus_req never asserted.
- TIMEOUT_CYCLES=4, lw aligned, ack never arrives → exc_bus pulses after 4 BUSY cycles, req drops, state IDLE, stall_M=0.
- reset_n pulled low during BUSY → dbus_req=0 and all W outputs 0 immediately; after release, the next instruction proceeds normally.
